// File: rtl/decode_scan_onehot_pkg.sv
// Shared types and constants for the one-hot decoder / scanner block.
// Optional feature macro: DECODE_SCAN_BLANK_EN (one blank cycle per scan advance).
package decode_pkg;

    // Controller states; OFF is the reset state.
    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2,
        ST_BLANK  = 2'd3
    } dec_state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decode_scan_onehot_if.sv
// Control/output bundle of the one-hot decoder / scanner.
// Handshake: none. The inputs (en, mode, x, div) are level signals sampled
// on every rising clk edge; the outputs (y, idx, wrap) are registered and
// valid one cycle after the edge that produced them.
interface decode_scan_onehot_if #(
    parameter int SEL_W = 3,
    parameter int N_OUT = 8,
    parameter int DIV_W = 16
);
    logic             en;
    logic             mode;
    logic [SEL_W-1:0] x;
    logic [DIV_W-1:0] div;
    logic [N_OUT-1:0] y;
    logic [SEL_W-1:0] idx;
    logic             wrap;

    // Driver side (board logic or bench).
    modport master (
        output en, mode, x, div,
        input  y, idx, wrap
    );

    // Decoder side.
    modport slave (
        input  en, mode, x, div,
        output y, idx, wrap
    );
endinterface

// File: rtl/decode_scan_onehot_onehot.sv
// Combinational binary-to-one-hot decoder; a select at or above N_OUT
// decodes to all-zero so out-of-range values never light an output.
module dec_onehot #(
    parameter int SEL_W = 3,
    parameter int N_OUT = 8
) (
    input  logic [SEL_W-1:0] sel_i,
    output logic [N_OUT-1:0] onehot_o
);

    // Set only the bit whose position equals the select value.
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (int'(sel_i) == i) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_scan_onehot.sv
// Registered one-hot decoder with DIRECT (decode x) and SCAN (self-stepping
// index) modes. Define DECODE_SCAN_BLANK_EN to insert one all-zero cycle
// on every scan advance (ghosting suppression on multiplexed displays).
module decode_scan_onehot
    import decode_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int N_OUT = 8,
    parameter int DIV_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    decode_scan_onehot_if.slave        bus,
    output dec_state_t                 state_o
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_OUT - 1);

    dec_state_t       state_q, state_d;
    logic [DIV_W-1:0] cnt_q,   cnt_d;
    logic [SEL_W-1:0] idx_q,   idx_d;
    logic [N_OUT-1:0] y_q,     y_d;
    logic             wrap_q,  wrap_d;
    logic             show_d;
    logic [N_OUT-1:0] onehot_next;
    logic             at_last;

    assign at_last = (idx_q == LAST_IDX);

    // The decoder sits on the next-index path so y and idx update together.
    dec_onehot #(
        .SEL_W (SEL_W),
        .N_OUT (N_OUT)
    ) u_dec (
        .sel_i    (idx_d),
        .onehot_o (onehot_next)
    );

    // Next-state, dwell counter, index and output decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        show_d  = 1'b0;
        if (!bus.en) begin
            // Off: outputs dark, idx kept for inspection.
            state_d = ST_OFF;
            cnt_d   = '0;
        end else if (bus.mode == MODE_DIRECT) begin
            state_d = ST_DIRECT;
            idx_d   = bus.x;
            cnt_d   = '0;
            show_d  = 1'b1;
        end else begin
            case (state_q)
                ST_SCAN: begin
                    show_d = 1'b1;
                    // >= so a live div lowered below cnt advances immediately.
                    if (cnt_q >= bus.div) begin
                        cnt_d = '0;
                        idx_d = at_last ? '0 : idx_q + 1'b1;
`ifdef DECODE_SCAN_BLANK_EN
                        state_d = ST_BLANK;
                        show_d  = 1'b0;
`else
                        wrap_d  = at_last;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_BLANK: begin
                    // idx already advanced; index 0 here can only be a wrap.
                    state_d = ST_SCAN;
                    show_d  = 1'b1;
                    wrap_d  = (idx_q == '0);
                end
                default: begin
                    // Entering SCAN from OFF or DIRECT restarts at index 0.
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    cnt_d   = '0;
                    show_d  = 1'b1;
                end
            endcase
        end
        y_d = show_d ? onehot_next : '0;
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            idx_q   <= '0;
            y_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.y    = y_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
    assign state_o  = state_q;

endmodule
